taxel_scanner: RTL and testbench

- Produces the 12-bit sample stream that the colour mapper consumes.
- Raster-scans the tactile sensor matrix: selects one switch (drive) wire and one read wire at a time, waits for the analog path to settle, handshakes one ADC conversion, and writes the sample into the frame RAM.
- Frame RAM address = sw_idx*RD_WIRE_CNT + rd_idx.
- Sits between the analog mux/ADC front end and the frame RAM read by the display path.

---
 rtl/taxel_scanner_pkg.sv | 26 ++
 rtl/taxel_scanner_if.sv | 39 +++
 rtl/taxel_scanner_settle_timer.sv | 37 +++
 rtl/taxel_scanner.sv | 182 ++++++++++++++++++
 tb/tb_taxel_scanner.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/taxel_scanner_pkg.sv
// Shared types and constants for the tactile matrix scanner.
package tactile_pkg;

  localparam int SAMPLE_W = 12;

  localparam int DEFAULT_SW_WIRE_CNT = 16;
  localparam int DEFAULT_RD_WIRE_CNT = 16;

  // Index width for a count of items; a single item still needs a one-bit select.
  function automatic int idx_width(input int cnt);
    return (cnt > 1) ? $clog2(cnt) : 1;
  endfunction

  localparam int DEFAULT_SW_SEL_W = idx_width(DEFAULT_SW_WIRE_CNT);
  localparam int DEFAULT_RD_SEL_W = idx_width(DEFAULT_RD_WIRE_CNT);
  localparam int DEFAULT_ADDR_W   = idx_width(DEFAULT_SW_WIRE_CNT * DEFAULT_RD_WIRE_CNT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CONVERT,
    ST_WAIT_ADC,
    ST_WRITE
  } scan_state_e;

endpackage

// File: rtl/taxel_scanner_if.sv
// Scanner bus: analog mux selects, ADC handshake, frame RAM write port and status.
interface taxel_scanner_if
  import tactile_pkg::*;
#(
  parameter int SW_WIRE_CNT = DEFAULT_SW_WIRE_CNT,
  parameter int RD_WIRE_CNT = DEFAULT_RD_WIRE_CNT
);

  localparam int SW_SEL_W = idx_width(SW_WIRE_CNT);
  localparam int RD_SEL_W = idx_width(RD_WIRE_CNT);
  localparam int ADDR_W   = idx_width(SW_WIRE_CNT * RD_WIRE_CNT);

  logic                scan_en;
  logic [SW_SEL_W-1:0] sw_sel;
  logic                sw_drive_en;
  logic [RD_SEL_W-1:0] rd_sel;
  logic                adc_start;
  logic                adc_valid;
  logic [SAMPLE_W-1:0] adc_data;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [SAMPLE_W-1:0] wr_data;
  logic                frame_done;
  logic                adc_err;
  logic                busy;

  modport master (
    input  scan_en, adc_valid, adc_data,
    output sw_sel, sw_drive_en, rd_sel, adc_start,
           wr_en, wr_addr, wr_data, frame_done, adc_err, busy
  );

  modport slave (
    output scan_en, adc_valid, adc_data,
    input  sw_sel, sw_drive_en, rd_sel, adc_start,
           wr_en, wr_addr, wr_data, frame_done, adc_err, busy
  );

endinterface

// File: rtl/taxel_scanner_settle_timer.sv
// Loadable down-counter that flags the final cycle of an analog settle window.
module scan_settle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load takes priority over counting; the count parks at zero rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/taxel_scanner.sv
// Raster scanner: settles each taxel, runs one ADC conversion and writes the sample to frame RAM.
module taxel_scanner
  import tactile_pkg::*;
#(
  parameter int SW_WIRE_CNT      = DEFAULT_SW_WIRE_CNT,
  parameter int RD_WIRE_CNT      = DEFAULT_RD_WIRE_CNT,
  parameter int SW_SETTLE_CYCLES = 64,
  parameter int RD_SETTLE_CYCLES = 8,
  parameter int ADC_TIMEOUT      = 1023
) (
  input logic             clk,
  input logic             rst,
  taxel_scanner_if.master bus
);

  localparam int SW_SEL_W   = idx_width(SW_WIRE_CNT);
  localparam int RD_SEL_W   = idx_width(RD_WIRE_CNT);
  localparam int ADDR_W     = idx_width(SW_WIRE_CNT * RD_WIRE_CNT);
  localparam int MAX_SETTLE = (SW_SETTLE_CYCLES > RD_SETTLE_CYCLES) ? SW_SETTLE_CYCLES : RD_SETTLE_CYCLES;
  localparam int SETTLE_W   = $clog2(MAX_SETTLE + 1);
  localparam int TMO_W      = $clog2(ADC_TIMEOUT + 1);

  localparam logic [SW_SEL_W-1:0] SW_LAST   = SW_SEL_W'(SW_WIRE_CNT - 1);
  localparam logic [RD_SEL_W-1:0] RD_LAST   = RD_SEL_W'(RD_WIRE_CNT - 1);
  localparam logic [SETTLE_W-1:0] SW_SETTLE = SETTLE_W'(SW_SETTLE_CYCLES);
  localparam logic [SETTLE_W-1:0] RD_SETTLE = SETTLE_W'(RD_SETTLE_CYCLES);
  localparam logic [TMO_W-1:0]    TMO_LIMIT = TMO_W'(ADC_TIMEOUT);

  scan_state_e         state_q, state_d;
  logic [SW_SEL_W-1:0] sw_q, sw_d;
  logic [RD_SEL_W-1:0] rd_q, rd_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [SAMPLE_W-1:0] wr_data_q, wr_data_d;

  logic                settle_load;
  logic [SETTLE_W-1:0] settle_val;
  logic                settle_dec;
  logic                settle_done;

  logic                adc_start;
  logic                wr_en;
  logic                frame_done;
  logic                adc_err;

  logic [ADDR_W-1:0]   taxel_addr;
  logic [TMO_W-1:0]    tmo_next;

  // Row-major address at full width so non-power-of-two grids pack without gaps.
  assign taxel_addr = (ADDR_W'(sw_q) * ADDR_W'(RD_WIRE_CNT)) + ADDR_W'(rd_q);
  assign tmo_next   = tmo_q + 1'b1;

  scan_settle_timer #(
    .CNT_W (SETTLE_W)
  ) u_settle (
    .clk        (clk),
    .rst        (rst),
    .load_i     (settle_load),
    .load_val_i (settle_val),
    .dec_i      (settle_dec),
    .done_o     (settle_done)
  );

  // Next-state, index advance and strobe decode for the scan FSM.
  always_comb begin
    state_d     = state_q;
    sw_d        = sw_q;
    rd_d        = rd_q;
    tmo_d       = tmo_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    settle_load = 1'b0;
    settle_val  = SW_SETTLE;
    settle_dec  = 1'b0;
    adc_start   = 1'b0;
    wr_en       = 1'b0;
    frame_done  = 1'b0;
    adc_err     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.scan_en) begin
          sw_d        = '0;
          rd_d        = '0;
          settle_load = 1'b1;
          settle_val  = SW_SETTLE;
          state_d     = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        settle_dec = 1'b1;
        if (settle_done) begin
          state_d = ST_CONVERT;
        end
      end

      ST_CONVERT: begin
        adc_start = 1'b1;
        tmo_d     = '0;
        state_d   = ST_WAIT_ADC;
      end

      ST_WAIT_ADC: begin
        tmo_d = tmo_next;
        if (bus.adc_valid) begin
          wr_data_d = bus.adc_data;
          wr_addr_d = taxel_addr;
          state_d   = ST_WRITE;
        end else if (tmo_next == TMO_LIMIT) begin
          wr_data_d = '0;
          wr_addr_d = taxel_addr;
          adc_err   = 1'b1;
          state_d   = ST_WRITE;
        end
      end

      ST_WRITE: begin
        wr_en = 1'b1;
        if (rd_q < RD_LAST) begin
          rd_d        = rd_q + 1'b1;
          settle_load = 1'b1;
          settle_val  = RD_SETTLE;
          state_d     = ST_SETTLE;
        end else begin
          rd_d = '0;
          if (sw_q < SW_LAST) begin
            sw_d        = sw_q + 1'b1;
            settle_load = 1'b1;
            settle_val  = SW_SETTLE;
            state_d     = ST_SETTLE;
          end else begin
            sw_d       = '0;
            frame_done = 1'b1;
            if (bus.scan_en) begin
              settle_load = 1'b1;
              settle_val  = SW_SETTLE;
              state_d     = ST_SETTLE;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, index, timeout and write-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sw_q      <= '0;
      rd_q      <= '0;
      tmo_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      sw_q      <= sw_d;
      rd_q      <= rd_d;
      tmo_q     <= tmo_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.sw_sel      = sw_q;
  assign bus.rd_sel      = rd_q;
  assign bus.sw_drive_en = (state_q != ST_IDLE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.adc_start   = adc_start;
  assign bus.wr_en       = wr_en;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.frame_done  = frame_done;
  assign bus.adc_err     = adc_err;

endmodule

// File: tb/tb_taxel_scanner.sv
// Scoreboard bench for taxel_scanner: a 2x2 grid with short settles and timeout, plus a 3x5 grid.
module tb_taxel_scanner;
  import tactile_pkg::*;

  localparam int A_SW  = 2;
  localparam int A_RD  = 2;
  localparam int A_SWS = 4;
  localparam int A_RDS = 2;
  localparam int A_TMO = 10;
  localparam int B_SW  = 3;
  localparam int B_RD  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A: 2x2 grid ----------------
  taxel_scanner_if #(.SW_WIRE_CNT(A_SW), .RD_WIRE_CNT(A_RD)) busA ();

  taxel_scanner #(
    .SW_WIRE_CNT(A_SW), .RD_WIRE_CNT(A_RD),
    .SW_SETTLE_CYCLES(A_SWS), .RD_SETTLE_CYCLES(A_RDS), .ADC_TIMEOUT(A_TMO)
  ) dutA (.clk(clk), .rst(rst), .bus(busA));

  logic        scanEnA    = 1'b0;
  logic        modelValid = 1'b0;
  logic        spurValid  = 1'b0;
  logic [11:0] modelData  = '0;

  assign busA.scan_en   = scanEnA;
  assign busA.adc_valid = modelValid | spurValid;
  assign busA.adc_data  = spurValid ? 12'hDEA : modelData;

  typedef struct { int addr; int data; bit err; bit fd; int lat; } exp_t;
  typedef struct { int delay; int data; } adc_t;

  exp_t expQ[$];
  adc_t adcQ[$];

  // ---------------- DUT B: 3x5 grid ----------------
  taxel_scanner_if #(.SW_WIRE_CNT(B_SW), .RD_WIRE_CNT(B_RD)) busB ();

  taxel_scanner #(
    .SW_WIRE_CNT(B_SW), .RD_WIRE_CNT(B_RD),
    .SW_SETTLE_CYCLES(1), .RD_SETTLE_CYCLES(1), .ADC_TIMEOUT(1023)
  ) dutB (.clk(clk), .rst(rst), .bus(busB));

  logic        scanEnB = 1'b0;
  logic        validB  = 1'b0;
  logic [11:0] dataB   = '0;
  int          convB   = 0;
  int          idxB    = 0;

  assign busB.scan_en   = scanEnB;
  assign busB.adc_valid = validB;
  assign busB.adc_data  = dataB;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Queue one taxel: ADC behaviour (delay 0 = silent) and the write it must produce.
  task automatic applyStimulus(input int addr, input int delay, input int adcData, input bit fd);
    exp_t e;
    adc_t a;
    a.delay = delay;
    a.data  = adcData;
    adcQ.push_back(a);
    e.addr = addr;
    e.fd   = fd;
    if (delay == 0 || delay > A_TMO) begin
      e.data = 0; e.err = 1'b1; e.lat = A_TMO + 1;
    end else begin
      e.data = adcData; e.err = 1'b0; e.lat = delay + 1;
    end
    expQ.push_back(e);
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, "_sw_sel"},     busA.sw_sel, 0);
    checkOutput({tag, "_rd_sel"},     busA.rd_sel, 0);
    checkOutput({tag, "_busy"},       busA.busy, 0);
    checkOutput({tag, "_drive_en"},   busA.sw_drive_en, 0);
    checkOutput({tag, "_wr_en"},      busA.wr_en, 0);
    checkOutput({tag, "_adc_start"},  busA.adc_start, 0);
    checkOutput({tag, "_wr_addr"},    busA.wr_addr, 0);
    checkOutput({tag, "_wr_data"},    busA.wr_data, 0);
    checkOutput({tag, "_frame_done"}, busA.frame_done, 0);
    checkOutput({tag, "_adc_err"},    busA.adc_err, 0);
  endtask

  task automatic waitDrain(input string name, input int maxCyc);
    int n = 0;
    while (expQ.size() != 0 && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s pending=%0d required=0", name, expQ.size());
    end
  endtask

  // ADC model for A: answers each adc_start after the queued delay, aborts on reset.
  initial begin : adcModelA
    adc_t e;
    bit   aborted;
    forever begin
      @(negedge clk);
      if (!rst && busA.adc_start) begin
        if (adcQ.size() == 0) begin
          e.delay = 0; e.data = 0;
        end else begin
          e = adcQ.pop_front();
        end
        if (e.delay > 0) begin
          aborted = 1'b0;
          for (int i = 0; i < e.delay; i++) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
          end
          if (!aborted && !rst) begin
            modelValid = 1'b1;
            modelData  = e.data[11:0];
            @(negedge clk);
            modelValid = 1'b0;
          end
        end
      end
    end
  end

  int  cyc = 0;
  int  lastStart = 0;
  int  lastWr = 0;
  int  busyRise = 0;
  bit  prevBusy = 1'b0;
  bit  firstPending = 1'b0;
  bit  sawErr = 1'b0;
  int  pendGap = 0;
  int  frameDones = 0;

  // Monitor for A: pops the scoreboard on every write and checks settle/latency spacing.
  always @(negedge clk) begin : monitorA
    exp_t e;
    cyc++;
    if (rst) begin
      prevBusy = 1'b0; sawErr = 1'b0; pendGap = 0; firstPending = 1'b0;
    end else begin
      if (busA.busy && !prevBusy) begin
        busyRise = cyc; firstPending = 1'b1;
      end
      if (busA.adc_start) begin
        if (firstPending) checkOutput("first_settle", cyc - busyRise, A_SWS);
        else if (pendGap != 0) checkOutput("settle_gap", cyc - lastWr, pendGap);
        firstPending = 1'b0; pendGap = 0; lastStart = cyc;
      end
      if (busA.adc_err) begin
        sawErr = 1'b1;
        checkOutput("err_latency", cyc - lastStart, A_TMO);
      end
      if (busA.wr_en) begin
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_wr addr=%0d required=none", busA.wr_addr);
        end else begin
          e = expQ.pop_front();
          checkOutput("wr_addr", busA.wr_addr, e.addr);
          checkOutput("wr_data", busA.wr_data, e.data);
          checkOutput("frame_done", busA.frame_done, e.fd);
          checkOutput("adc_err_seen", sawErr, e.err);
          checkOutput("wr_latency", cyc - lastStart, e.lat);
          pendGap = ((e.addr % A_RD) == A_RD - 1) ? A_SWS + 1 : A_RDS + 1;
        end
        if (busA.frame_done) frameDones++;
        lastWr = cyc; sawErr = 1'b0;
      end
      if (!busA.busy) pendGap = 0;
      prevBusy = busA.busy;
    end
  end

  // ADC responder for B: replies one cycle after each request with conversion number * 7.
  initial begin : adcModelB
    forever begin
      @(negedge clk);
      if (!rst && busB.adc_start) begin
        @(negedge clk);
        validB = 1'b1;
        dataB  = 12'(convB * 7);
        convB++;
        @(negedge clk);
        validB = 1'b0;
      end
    end
  end

  // Monitor for B: selects stay in range and writes arrive in strict address order.
  always @(negedge clk) begin : monitorB
    if (!rst && busB.busy) begin
      checkOutput("B_sw_range", busB.sw_sel <= 2, 1);
      checkOutput("B_rd_range", busB.rd_sel <= 4, 1);
    end
    if (!rst && busB.wr_en) begin
      checkOutput("B_wr_addr", busB.wr_addr, idxB);
      checkOutput("B_wr_data", busB.wr_data, (idxB * 7) & 12'hFFF);
      checkOutput("B_frame_done", busB.frame_done, idxB == B_SW * B_RD - 1);
      idxB++;
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkResetA("reset");

    // Three back-to-back frames; scan_en dropped early in the third.
    for (int f = 0; f < 3; f++)
      for (int a = 0; a < 4; a++)
        applyStimulus(a, 3, a * 100 + f, a == 3);
    scanEnA = 1'b1;
    n = 0;
    while (expQ.size() > 3 && n < 400) begin @(negedge clk); n++; end
    scanEnA = 1'b0;
    waitDrain("frames_drain", 400);
    @(negedge clk);
    checkOutput("idle_busy", busA.busy, 0);
    checkOutput("idle_drive_en", busA.sw_drive_en, 0);
    checkOutput("frame_count", frameDones, 3);
    repeat (20) @(negedge clk);

    // Timeout, valid-on-timeout and a spurious valid while settling.
    applyStimulus(0, 2, 12'h111, 1'b0);
    applyStimulus(1, 0, 0, 1'b0);
    applyStimulus(2, A_TMO, 12'hABC, 1'b0);
    applyStimulus(3, 1, 12'h7FF, 1'b1);
    scanEnA = 1'b1;
    n = 0;
    while (!busA.busy && n < 20) begin @(negedge clk); n++; end
    scanEnA = 1'b0;
    n = 0;
    while (expQ.size() > 3 && n < 100) begin @(negedge clk); n++; end
    spurValid = 1'b1;
    @(negedge clk);
    spurValid = 1'b0;
    waitDrain("timeout_drain", 400);
    @(negedge clk);
    checkOutput("timeout_frame_idle", busA.busy, 0);
    repeat (10) @(negedge clk);

    // 3x5 grid on the second instance.
    scanEnB = 1'b1;
    n = 0;
    while (!busB.busy && n < 20) begin @(negedge clk); n++; end
    scanEnB = 1'b0;
    n = 0;
    while (idxB < B_SW * B_RD && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    checkOutput("B_write_count", idxB, B_SW * B_RD);
    checkOutput("B_idle_busy", busB.busy, 0);

    // Reset while waiting on the ADC abandons the frame.
    applyStimulus(0, 6, 12'h005, 1'b0);
    scanEnA = 1'b1;
    n = 0;
    while (!busA.adc_start && n < 50) begin @(negedge clk); n++; end
    checkOutput("reset_test_start_seen", busA.adc_start, 1);
    repeat (2) @(negedge clk);
    scanEnA = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkResetA("midreset");
    @(negedge clk);
    rst = 1'b0;
    expQ.delete();
    adcQ.delete();
    repeat (30) @(negedge clk);
    checkOutput("post_reset_busy", busA.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
